// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between an initiator (master) and the
// single-outstanding memory responder (slave).
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder: accept in IDLE, wait LATENCY
// cycles, perform the access, then hold the response until it is consumed.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state_reg;
  logic [3:0]             cnt_reg;
  logic                   we_reg;
  logic [31:0]            addr_reg;
  logic [31:0]            wdata_reg;
  logic                   req_ready_reg;
  logic                   resp_valid_reg;
  logic                   resp_err_reg;
  logic                   rdata_ok_reg;
  logic [31:0]            rd_data_reg;
  logic [31:0]            mem [DEPTH];

  logic [ADDR_WIDTH-1:0]  word_idx;
  logic                   addr_err;
  logic                   access;

  assign word_idx = addr_reg[ADDR_WIDTH+1:2];
  assign addr_err = (addr_reg[1:0] != 2'b00) || (addr_reg[31:ADDR_WIDTH+2] != '0);
  assign access   = (state_reg == WAIT) && (cnt_reg == 4'd0);

  // Array kept out of the reset domain so it maps to block RAM and survives reset.
  always_ff @(posedge clk) begin
    if (access && !addr_err) begin
      if (we_reg)
        mem[word_idx] <= wdata_reg;
      else
        rd_data_reg <= mem[word_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      rdata_ok_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            we_reg        <= bus.req_we;
            addr_reg      <= bus.req_addr;
            wdata_reg     <= bus.req_wdata;
            cnt_reg       <= CNT_INIT;
            req_ready_reg <= 1'b0;
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= addr_err;
            rdata_ok_reg   <= !addr_err && !we_reg;
            state_reg      <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            rdata_ok_reg   <= 1'b0;
            req_ready_reg  <= 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: begin
          resp_valid_reg <= 1'b0;
          req_ready_reg  <= 1'b1;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  // Read data only surfaces for a successful read; writes and errors return 0.
  assign bus.resp_rdata = rdata_ok_reg ? rd_data_reg : 32'h0;
  assign bus.req_ready  = req_ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_err   = resp_err_reg;
endmodule
